// File: rtl/alu_seq_pkg.sv
// Shared definitions for the CB-prefix rotate/shift sequencer and the ALU it drives.
// Holds the ALU control bundle, the shifter/output-enable/load encodings (the single
// source for these values on both sides of the ALU control bus), the rotate opcode
// and sequencer state enums, and the quiescent control word IDLE_CTL.
package alu_seq_pkg;

    typedef enum logic [1:0] {
        NO_SH = 2'd0,
        L_SH  = 2'd1,
        R_SH  = 2'd2
    } sh_e;

    typedef enum logic [1:0] {
        NO_OE  = 2'd0,
        SH_OE  = 2'd1,
        RES_OE = 2'd2
    } oe_e;

    typedef enum logic {
        NO_LD  = 1'b0,
        BUS_LD = 1'b1
    } ld_e;

    typedef enum logic [2:0] {
        ROT_RLC  = 3'd0,
        ROT_RRC  = 3'd1,
        ROT_RL   = 3'd2,
        ROT_RR   = 3'd3,
        ROT_SLA  = 3'd4,
        ROT_SRA  = 3'd5,
        ROT_SWAP = 3'd6,
        ROT_SRL  = 3'd7
    } rot_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_OUT  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    typedef struct packed {
        logic [7:0] op;
        logic       si;
        sh_e        sh;
        oe_e        oe;
        ld_e        la;
        ld_e        lb;
        logic       r;
        logic       s;
        logic       v;
        logic       ne;
        logic       ci;
        logic       l;
        logic       h;
    } alu_ctl_t;

    localparam alu_ctl_t IDLE_CTL = '{
        op: 8'h00, si: 1'b0, sh: NO_SH, oe: NO_OE, la: NO_LD, lb: NO_LD,
        r: 1'b0, s: 1'b0, v: 1'b0, ne: 1'b0, ci: 1'b0, l: 1'b0, h: 1'b0
    };

endpackage

// File: rtl/alu_rot_decode.sv
// Combinational decode of a rotate/shift opcode into shifter controls.
// Ports:
//   op          rotate opcode
//   data_hi     operand bit 7
//   data_lo     operand bit 0
//   c           incoming carry flag
//   sh          shifter direction
//   si          bit shifted into the vacated position
//   carry_hi    1: carry-out is the ALU high shifted-out bit, 0: the low one
//   unsupported opcode the sequencer does not run through the ALU (SWAP)
module alu_rot_decode
    import alu_seq_pkg::*;
(
    input  rot_op_e op,
    input  logic    data_hi,
    input  logic    data_lo,
    input  logic    c,
    output sh_e     sh,
    output logic    si,
    output logic    carry_hi,
    output logic    unsupported
);

    always_comb begin
        sh          = NO_SH;
        si          = 1'b0;
        carry_hi    = 1'b0;
        unsupported = 1'b0;
        case (op)
            ROT_RLC: begin sh = L_SH; si = data_hi; carry_hi = 1'b1; end
            ROT_RRC: begin sh = R_SH; si = data_lo; end
            ROT_RL:  begin sh = L_SH; si = c;       carry_hi = 1'b1; end
            ROT_RR:  begin sh = R_SH; si = c;       end
            ROT_SLA: begin sh = L_SH; si = 1'b0;    carry_hi = 1'b1; end
            // Arithmetic right shift replicates the sign bit.
            ROT_SRA: begin sh = R_SH; si = data_hi; end
            ROT_SRL: begin sh = R_SH; si = 1'b0;    end
            default: unsupported = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_rot_seq.sv
// Sequences the shared ALU through the load/shift then result-output pattern for the
// CB-prefix rotate/shift group and returns the result with a one-cycle done pulse.
// Ports:
//   clk, nreset          clock, asynchronous active-low reset
//   req_valid/req_ready  request handshake (ready only while idle)
//   req_op/req_data/req_c rotate opcode, operand byte, current carry flag
//   alu_ctl              ALU control bundle, decoded from state and latched request only
//   alu_result/alu_zero  ALU result bus and zero output
//   alu_shift_dbh/dbl    ALU shifted-out high/low bit
//   done                 one-cycle pulse, res_data/res_flags/err valid
//   res_data/res_flags   captured result and {Z,N,H,C}
//   err                  unsupported opcode (SWAP), held until the next accept
module alu_rot_seq
    import alu_seq_pkg::*;
#(
    parameter bit CAPTURE_ZERO = 1'b1
) (
    input  logic       clk,
    input  logic       nreset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [2:0] req_op,
    input  logic [7:0] req_data,
    input  logic       req_c,
    output alu_ctl_t   alu_ctl,
    input  logic [7:0] alu_result,
    input  logic       alu_zero,
    input  logic       alu_shift_dbh,
    input  logic       alu_shift_dbl,
    output logic       done,
    output logic [7:0] res_data,
    output logic [3:0] res_flags,
    output logic       err
);

    state_e     state, state_nx;
    rot_op_e    op_q;
    logic [7:0] data_q;
    logic       c_q;
    logic       carry_q;

    rot_op_e    dec_op;
    sh_e        dec_sh;
    logic       dec_si;
    logic       dec_carry_hi;
    logic       dec_unsupported;
    logic       accept;
    logic       z_val;

    // While idle the decoder looks at the incoming opcode so SWAP can be
    // rejected at accept time; alu_ctl ignores decoder outputs in IDLE, so
    // there is still no path from req_* to alu_ctl.
    assign dec_op = (state == ST_IDLE) ? rot_op_e'(req_op) : op_q;
    assign accept = (state == ST_IDLE) && req_valid;
    assign z_val  = CAPTURE_ZERO ? alu_zero : (alu_result == 8'h00);

    alu_rot_decode u_decode (
        .op          (dec_op),
        .data_hi     (data_q[7]),
        .data_lo     (data_q[0]),
        .c           (c_q),
        .sh          (dec_sh),
        .si          (dec_si),
        .carry_hi    (dec_carry_hi),
        .unsupported (dec_unsupported)
    );

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) state <= ST_IDLE;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx = ST_IDLE;
        case (state)
            ST_IDLE: begin
                state_nx = ST_IDLE;
                if (req_valid) state_nx = dec_unsupported ? ST_DONE : ST_LOAD;
            end
            ST_LOAD: state_nx = ST_OUT;
            ST_OUT:  state_nx = ST_DONE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        alu_ctl = IDLE_CTL;
        case (state)
            ST_LOAD: begin
                alu_ctl.op = data_q;
                alu_ctl.sh = dec_sh;
                alu_ctl.si = dec_si;
                alu_ctl.la = BUS_LD;
                alu_ctl.lb = BUS_LD;
                alu_ctl.oe = SH_OE;
                alu_ctl.r  = 1'b1;
                alu_ctl.s  = 1'b1;
                alu_ctl.v  = 1'b1;
                alu_ctl.l  = 1'b1;
            end
            ST_OUT: begin
                alu_ctl.oe = RES_OE;
                alu_ctl.r  = 1'b1;
                alu_ctl.s  = 1'b1;
                alu_ctl.v  = 1'b1;
                alu_ctl.h  = 1'b1;
            end
            default: alu_ctl = IDLE_CTL;
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            op_q      <= ROT_RLC;
            data_q    <= 8'h00;
            c_q       <= 1'b0;
            carry_q   <= 1'b0;
            err       <= 1'b0;
            res_data  <= 8'h00;
            res_flags <= 4'h0;
        end else begin
            if (accept) begin
                op_q   <= rot_op_e'(req_op);
                data_q <= req_data;
                c_q    <= req_c;
                err    <= dec_unsupported;
            end
            // Carry-out is only visible on the shifter outputs during the load cycle.
            if (state == ST_LOAD)
                carry_q <= dec_carry_hi ? alu_shift_dbh : alu_shift_dbl;
            // Result and all flags commit together so they change in one step.
            if (state == ST_OUT) begin
                res_data  <= alu_result;
                res_flags <= {z_val, 1'b0, 1'b0, carry_q};
            end
        end
    end

    assign req_ready = (state == ST_IDLE);
    assign done      = (state == ST_DONE);

endmodule

// File: tb/tb_alu_rot_seq.sv
module tb_alu_rot_seq;
    import alu_seq_pkg::*;

    logic       clk = 1'b0;
    logic       nreset;
    logic       req_valid;
    logic       req_ready;
    logic [2:0] req_op;
    logic [7:0] req_data;
    logic       req_c;
    alu_ctl_t   alu_ctl;
    logic [7:0] alu_result;
    logic       alu_zero;
    logic       alu_shift_dbh;
    logic       alu_shift_dbl;
    logic       done;
    logic [7:0] res_data;
    logic [3:0] res_flags;
    logic       err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_rot_seq #(.CAPTURE_ZERO(1'b1)) dut (
        .clk           (clk),
        .nreset        (nreset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_op        (req_op),
        .req_data      (req_data),
        .req_c         (req_c),
        .alu_ctl       (alu_ctl),
        .alu_result    (alu_result),
        .alu_zero      (alu_zero),
        .alu_shift_dbh (alu_shift_dbh),
        .alu_shift_dbl (alu_shift_dbl),
        .done          (done),
        .res_data      (res_data),
        .res_flags     (res_flags),
        .err           (err)
    );

    // Simple ALU: shifter on the bus operand, result register loaded on la,
    // result driven onto the bus only when RES_OE is selected.
    logic [7:0] alu_reg = 8'h00;
    logic [7:0] alu_shifted;
    always_comb begin
        alu_shifted = alu_ctl.op;
        if (alu_ctl.sh == L_SH)      alu_shifted = {alu_ctl.op[6:0], alu_ctl.si};
        else if (alu_ctl.sh == R_SH) alu_shifted = {alu_ctl.si, alu_ctl.op[7:1]};
    end
    always @(posedge clk) if (alu_ctl.la == BUS_LD) alu_reg <= alu_shifted;
    assign alu_result    = (alu_ctl.oe == RES_OE) ? alu_reg : 8'h5A;
    assign alu_zero      = (alu_result == 8'h00);
    assign alu_shift_dbh = alu_ctl.op[7];
    assign alu_shift_dbl = alu_ctl.op[0];

    // done and req_ready must never coincide.
    always @(negedge clk) begin
        if (nreset === 1'b1) begin
            checks++;
            if (done === 1'b1 && req_ready === 1'b1) begin
                failures++;
                $display("FAIL done_with_ready: done=%b req_ready=%b required not both 1", done, req_ready);
            end
        end
    end

    // Reference: rotate/shift semantics with plain integer arithmetic.
    function automatic void ref_rot(input logic [2:0] op, input logic [7:0] d, input logic c,
                                    output logic [7:0] r, output logic co, output logic e);
        int v;
        int res;
        v = int'(d);
        res = 0;
        co = 1'b0;
        e = 1'b0;
        case (op)
            3'd0: begin res = (v * 2) % 256 + v / 128;  co = (v / 128) != 0; end
            3'd1: begin res = v / 2 + (v % 2) * 128;    co = (v % 2) != 0;   end
            3'd2: begin res = (v * 2) % 256 + int'(c);  co = (v / 128) != 0; end
            3'd3: begin res = v / 2 + int'(c) * 128;    co = (v % 2) != 0;   end
            3'd4: begin res = (v * 2) % 256;            co = (v / 128) != 0; end
            3'd5: begin res = v / 2 + (v / 128) * 128;  co = (v % 2) != 0;   end
            3'd7: begin res = v / 2;                    co = (v % 2) != 0;   end
            default: e = 1'b1;
        endcase
        r = 8'(res);
    endfunction

    function automatic alu_ctl_t exp_ctl(input int phase, input logic [7:0] d,
                                         input logic si, input logic left);
        alu_ctl_t e;
        e = IDLE_CTL;
        if (phase == 1) begin
            e.op = d; e.si = si; e.sh = left ? L_SH : R_SH; e.oe = SH_OE;
            e.la = BUS_LD; e.lb = BUS_LD; e.r = 1'b1; e.s = 1'b1; e.v = 1'b1; e.l = 1'b1;
        end else if (phase == 2) begin
            e.oe = RES_OE; e.r = 1'b1; e.s = 1'b1; e.v = 1'b1; e.h = 1'b1;
        end
        return e;
    endfunction

    // Runs one request from idle (#1 after an edge) back to idle. With hold set,
    // req_valid stays high and req_* are scrambled while busy.
    task automatic run_op(input logic [2:0] op, input logic [7:0] d, input logic c, input bit hold);
        logic [7:0] r;
        logic co, e, si, left;
        logic [7:0] prev_data;
        logic [3:0] prev_flags, exp_flags;
        int n;
        ref_rot(op, d, c, r, co, e);
        left = (op == 3'd0) || (op == 3'd2) || (op == 3'd4);
        si = left ? r[0] : r[7];
        exp_flags = {(r == 8'h00), 1'b0, 1'b0, co};
        n = 0;
        while (req_ready !== 1'b1 && n < 10) begin @(posedge clk); #1; n++; end
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL ready_wait: req_ready=%b required 1", req_ready);
        end
        prev_data = res_data;
        prev_flags = res_flags;
        req_valid = 1'b1; req_op = op; req_data = d; req_c = c;
        @(posedge clk); #1;
        if (hold) begin
            req_op = 3'($urandom_range(0, 7)); req_data = 8'($urandom); req_c = 1'($urandom);
        end else req_valid = 1'b0;
        if (e) begin
            checks++;
            if (done !== 1'b1 || err !== 1'b1 || req_ready !== 1'b0) begin
                failures++;
                $display("FAIL swap_done: done=%b err=%b ready=%b required 1 1 0", done, err, req_ready);
            end
            checks++;
            if (alu_ctl !== IDLE_CTL) begin
                failures++;
                $display("FAIL swap_ctl: got %h required %h", alu_ctl, IDLE_CTL);
            end
            checks++;
            if (res_data !== prev_data || res_flags !== prev_flags) begin
                failures++;
                $display("FAIL swap_res_hold: got %h/%h required %h/%h", res_data, res_flags, prev_data, prev_flags);
            end
        end else begin
            checks++;
            if (alu_ctl !== exp_ctl(1, d, si, left)) begin
                failures++;
                $display("FAIL load_ctl op=%0d d=%h: got %h required %h", op, d, alu_ctl, exp_ctl(1, d, si, left));
            end
            checks++;
            if (req_ready !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
                failures++;
                $display("FAIL load_status: ready=%b done=%b err=%b required 0 0 0", req_ready, done, err);
            end
            if (hold) begin
                req_op = 3'($urandom_range(0, 7)); req_data = 8'($urandom); req_c = 1'($urandom);
            end
            @(posedge clk); #1;
            checks++;
            if (alu_ctl !== exp_ctl(2, d, si, left) || req_ready !== 1'b0 || done !== 1'b0) begin
                failures++;
                $display("FAIL out_ctl: got %h ready=%b done=%b required %h 0 0", alu_ctl, req_ready, done, exp_ctl(2, d, si, left));
            end
            @(posedge clk); #1;
            checks++;
            if (done !== 1'b1 || req_ready !== 1'b0 || err !== 1'b0) begin
                failures++;
                $display("FAIL done_pulse: done=%b ready=%b err=%b required 1 0 0", done, req_ready, err);
            end
            checks++;
            if (res_data !== r || res_flags !== exp_flags) begin
                failures++;
                $display("FAIL result op=%0d d=%h c=%b: got %h flags %b required %h flags %b", op, d, c, res_data, res_flags, r, exp_flags);
            end
            checks++;
            if (alu_ctl !== IDLE_CTL) begin
                failures++;
                $display("FAIL done_ctl: got %h required %h", alu_ctl, IDLE_CTL);
            end
        end
        @(posedge clk); #1;
        checks++;
        if (req_ready !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL back_idle: ready=%b done=%b required 1 0", req_ready, done);
        end
        checks++;
        if (res_data !== (e ? prev_data : r)) begin
            failures++;
            $display("FAIL res_hold: got %h required %h", res_data, e ? prev_data : r);
        end
    endtask

    task automatic test_reset();
        nreset = 1'b0; req_valid = 1'b0; req_op = 3'd0; req_data = 8'h00; req_c = 1'b0;
        #12;
        checks++;
        if (req_ready !== 1'b1 || done !== 1'b0 || err !== 1'b0) begin
            failures++;
            $display("FAIL reset_status: ready=%b done=%b err=%b required 1 0 0", req_ready, done, err);
        end
        checks++;
        if (res_data !== 8'h00 || res_flags !== 4'h0) begin
            failures++;
            $display("FAIL reset_res: got %h/%h required 00/0", res_data, res_flags);
        end
        checks++;
        if (alu_ctl !== IDLE_CTL) begin
            failures++;
            $display("FAIL reset_ctl: got %h required %h", alu_ctl, IDLE_CTL);
        end
        nreset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        run_op(3'd2, 8'h85, 1'b1, 1'b0);   // RL  -> 0x0B, C=1
        run_op(3'd7, 8'h01, 1'b1, 1'b0);   // SRL -> 0x00, Z=1 C=1
        run_op(3'd1, 8'h01, 1'b0, 1'b0);   // RRC -> 0x80, C=1
        run_op(3'd5, 8'h80, 1'b0, 1'b0);   // SRA -> 0xC0, C=0
        run_op(3'd0, 8'h80, 1'b0, 1'b0);   // RLC -> 0x01, C=1
        run_op(3'd3, 8'h00, 1'b0, 1'b0);   // RR  -> 0x00, Z=1
        run_op(3'd4, 8'hFF, 1'b0, 1'b0);   // SLA -> 0xFE, C=1
    endtask

    task automatic test_swap();
        run_op(3'd6, 8'hF0, 1'b0, 1'b0);
        // Next accept clears err (checked as err=0 during load).
        run_op(3'd2, 8'h40, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_op(3'd0, 8'hA5, 1'b0, 1'b1);
        run_op(3'd3, 8'h3C, 1'b1, 1'b1);
        run_op(3'd6, 8'h12, 1'b0, 1'b1);
        run_op(3'd7, 8'h02, 1'b0, 1'b1);
        req_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        int dn;
        req_valid = 1'b1; req_op = 3'd4; req_data = 8'h81; req_c = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (alu_ctl.oe !== RES_OE) begin
            failures++;
            $display("FAIL mid_in_out: oe=%0d required %0d", alu_ctl.oe, RES_OE);
        end
        #2 nreset = 1'b0;
        #1;
        checks++;
        if (alu_ctl !== IDLE_CTL || done !== 1'b0 || req_ready !== 1'b1) begin
            failures++;
            $display("FAIL mid_reset: ctl=%h done=%b ready=%b required %h 0 1", alu_ctl, done, req_ready, IDLE_CTL);
        end
        @(posedge clk); #2;
        nreset = 1'b1;
        dn = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (done !== 1'b0) dn++;
        end
        checks++;
        if (dn != 0 || req_ready !== 1'b1 || res_data !== 8'h00) begin
            failures++;
            $display("FAIL mid_after: done_pulses=%0d ready=%b res=%h required 0 1 00", dn, req_ready, res_data);
        end
        run_op(3'd1, 8'h02, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++)
            run_op(3'($urandom_range(0, 7)), 8'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0));
        req_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_swap();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_rot_seq.md
Name: alu_rot_seq

Overview:
- Sequences the shared ALU through the two-line load/shift/output pattern needed for the CB-prefix rotate/shift group: RLC, RRC, RL, RR, SLA, SRA, SWAP, SRL.
- Sits between instruction decode and the ALU control inputs.
- Accepts one request via a valid/ready handshake, drives the ALU control bundle, captures result and flags, and returns them with a one-cycle done pulse.

Parameters:
- CAPTURE_ZERO, 1, 1 = Z flag taken from ALU zero output; 0 = Z computed locally from captured result (bring-up cross-check).

Ports:
- clk  in  1  system clock
- nreset  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  sequencer idle, will accept request
- req_op  in  3  rotate op: 0 RLC, 1 RRC, 2 RL, 3 RR, 4 SLA, 5 SRA, 6 SWAP, 7 SRL
- req_data  in  8  operand byte
- req_c  in  1  current carry flag
- alu_ctl  out  alu_ctl_t  ALU control line bundle: op, si, sh, oe, la, lb, r, s, v, ne, ci, l, h
- alu_result  in  8  ALU result bus
- alu_zero  in  1  ALU zero output
- alu_shift_dbh  in  1  ALU shifted-out high bit
- alu_shift_dbl  in  1  ALU shifted-out low bit
- done  out  1  one-cycle pulse, result/flags valid
- res_data  out  8  captured result
- res_flags  out  4  {Z,N,H,C}
- err  out  1  with done: unsupported op (SWAP)

Behaviour:
- Reset, asynchronous, nreset low:
  - state=IDLE, req_ready=1, done=0, err=0, res_data=0, res_flags=0.
  - alu_ctl=IDLE_CTL: la=lb=NO_LD, oe=NO_OE, sh=NO_SH, op=0, si=0, r=s=v=0, ne=ci=l=h=0.
- States IDLE, LOAD, OUT, DONE. Transitions:
  - IDLE: req_ready=1. On req_valid, latch op/data/c. Next state is LOAD, or DONE with err=1 when op=SWAP (ALU untouched).
  - LOAD (cycle 1):
    - Control: op=data, la=lb=BUS_LD, oe=SH_OE, r=s=v=1, ne=ci=0, l=1, h=0.
    - sh and si per table:
      - RLC: L_SH, si=data[7]
      - RRC: R_SH, si=data[0]
      - RL: L_SH, si=c
      - RR: R_SH, si=c
      - SLA: L_SH, si=0
      - SRA: R_SH, si=data[7]
      - SRL: R_SH, si=0
    - Carry-out captured here: left ops C=alu_shift_dbh, right ops C=alu_shift_dbl.
    - Next: OUT.
  - OUT (cycle 2):
    - Control: la=lb=NO_LD, oe=RES_OE, r=s=v=1, ne=ci=0, l=0, h=1.
    - Capture res_data=alu_result; Z=alu_zero (or res==0 when CAPTURE_ZERO=0); N=H=0.
    - Next: DONE.
  - DONE (cycle 3): done=1, res_* stable, alu_ctl=IDLE_CTL. Next: IDLE.
- Latency: accept at cycle 0, done at cycle 3. Throughput: one op per 4 cycles.
- req_ready=0 in LOAD/OUT/DONE. req_valid there is ignored, not queued.
- res_data/res_flags hold until next capture. err clears on next accept.
- alu_ctl is registered-state-decoded: pure function of state plus latched request, no combinational path from req_* to alu_ctl.
- Reset mid-operation: immediate return to IDLE_CTL, no done pulse, latched request discarded.
- done is never asserted in the same cycle as req_ready.

Decomposition:
- Package alu_seq_pkg holds:
  - alu_ctl_t packed struct.
  - Enums sh_e {NO_SH, L_SH, R_SH}, oe_e {NO_OE, SH_OE, RES_OE}, ld_e {NO_LD, BUS_LD}.
  - rot_op_e, state_e.
  - IDLE_CTL constant.
  - sh/oe/ld values shared with the existing ALU definitions (single source).
- One sub-module: alu_rot_decode, purely combinational.
  - Inputs: rot_op_e, data[7], data[0], c.
  - Outputs: sh, si, carry-select (dbh/dbl), unsupported.
- FSM, capture registers and handshake stay in alu_rot_seq.

Test Plan:
- RL, data=0x85, c=1:
  - LOAD: sh=L_SH, si=1, la=lb=BUS_LD.
  - Model ALU yields 0x0B.
  - Done at cycle 3: res_data=0x0B, flags Z0 N0 H0 C1.
- SRL, data=0x01, c=1:
  - si=0, R_SH.
  - res_data=0x00, Z=1, C=1.
- RRC, data=0x01: si=1, res_data=0x80, C=1, Z=0. SRA, data=0x80: res_data=0xC0, C=0.
- SWAP, data=0xF0: no LOAD/OUT (alu_ctl stays IDLE_CTL), done at cycle 1 with err=1, res_data unchanged.
- Back-to-back: req_valid held high across two ops; second accepted only when req_ready returns (cycle 4); req_valid pulses in cycles 1-3 are ignored.
- nreset asserted during OUT: alu_ctl=IDLE_CTL immediately, no done pulse, req_ready=1 after release, next op completes normally.
